// File: rtl/bus_pkg.sv
// Shared definitions for the bus demultiplexer: FSM encoding, slave count,
// and the default address map.
package bus_pkg;

    localparam int NSLV = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    typedef logic [NSLV-1:0][31:0] addr_vec_t;

    // Default map: data RAM, LED/switch I/O, timer, UART
    localparam logic [31:0] DEF_BASE0 = 32'h0000_0000;
    localparam logic [31:0] DEF_MASK0 = 32'hFFFF_C000;
    localparam logic [31:0] DEF_BASE1 = 32'hFFFF_0000;
    localparam logic [31:0] DEF_MASK1 = 32'hFFFF_FF00;
    localparam logic [31:0] DEF_BASE2 = 32'hFFFF_0100;
    localparam logic [31:0] DEF_MASK2 = 32'hFFFF_FF00;
    localparam logic [31:0] DEF_BASE3 = 32'hFFFF_0200;
    localparam logic [31:0] DEF_MASK3 = 32'hFFFF_FF00;

endpackage

// File: rtl/bus_demux_if.sv
// Master-side request/response and slave-side select/ack bundle of the demux.
// The slave modport is the demux view; master is the surrounding system.
interface bus_demux_if;
    import bus_pkg::*;

    logic                 m_req;
    logic                 m_we;
    logic [31:0]          m_addr;
    logic [31:0]          m_wdata;
    logic [3:0]           m_be;
    logic                 m_ready;
    logic                 m_err;
    logic [31:0]          m_rdata;
    logic [NSLV-1:0]      s_sel;
    logic                 s_we;
    logic [31:0]          s_addr;
    logic [31:0]          s_wdata;
    logic [3:0]           s_be;
    logic [NSLV-1:0]      s_ack;
    logic [NSLV*32-1:0]   s_rdata;

    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_be, s_ack, s_rdata,
        output m_ready, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata, s_be
    );

    modport master (
        output m_req, m_we, m_addr, m_wdata, m_be, s_ack, s_rdata,
        input  m_ready, m_err, m_rdata, s_sel, s_we, s_addr, s_wdata, s_be
    );

endinterface

// File: rtl/bus_addr_decode.sv
// Combinational base/mask address decoder; the lowest matching slave wins.
module bus_addr_decode
    import bus_pkg::*;
#(
    parameter addr_vec_t BASE = {DEF_BASE3, DEF_BASE2, DEF_BASE1, DEF_BASE0},
    parameter addr_vec_t MASK = {DEF_MASK3, DEF_MASK2, DEF_MASK1, DEF_MASK0}
) (
    input  logic [31:0]     addr,
    output logic [NSLV-1:0] hit,
    output logic            miss
);

    logic [NSLV-1:0] match;

    genvar k;
    generate
        for (k = 0; k < NSLV; k++) begin : g_match
            assign match[k] = (addr & MASK[k]) == BASE[k];
        end
    endgenerate

    // Isolate the lowest set bit to get a one-hot, priority-resolved hit
    assign hit  = match & (~match + NSLV'(1));
    assign miss = ~|match;

endmodule

// File: rtl/bus_demux.sv
// Single-master to four-slave bus demultiplexer with one-cycle completion pulse.
// Define BUS_DEMUX_TIMEOUT_EN to abort transfers whose slave never acknowledges.
module bus_demux
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE0   = DEF_BASE0,
    parameter logic [31:0] MASK0   = DEF_MASK0,
    parameter logic [31:0] BASE1   = DEF_BASE1,
    parameter logic [31:0] MASK1   = DEF_MASK1,
    parameter logic [31:0] BASE2   = DEF_BASE2,
    parameter logic [31:0] MASK2   = DEF_MASK2,
    parameter logic [31:0] BASE3   = DEF_BASE3,
    parameter logic [31:0] MASK3   = DEF_MASK3,
    parameter int          TIMEOUT = 16
) (
    input  logic      clk,
    input  logic      rst,
    bus_demux_if.slave bus
);

    state_t          state, state_nxt;
    logic [NSLV-1:0] hit;
    logic            miss;
    logic [NSLV-1:0] sel_q;
    logic            we_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [3:0]      be_q;
    logic [31:0]     rdata_q;
    logic            ack_hit;
    logic            timeout_hit;
    logic [31:0]     slv_rdata;

    bus_addr_decode #(
        .BASE({BASE3, BASE2, BASE1, BASE0}),
        .MASK({MASK3, MASK2, MASK1, MASK0})
    ) u_dec (
        .addr (bus.m_addr),
        .hit  (hit),
        .miss (miss)
    );

    // Only the selected slave's ack and data are looked at
    assign ack_hit = |(bus.s_ack & sel_q);

    always_comb begin
        slv_rdata = '0;
        for (int k = 0; k < NSLV; k++)
            if (sel_q[k]) slv_rdata = slv_rdata | bus.s_rdata[k*32 +: 32];
    end

`ifdef BUS_DEMUX_TIMEOUT_EN
    logic [15:0] to_cnt;

    assign timeout_hit = (to_cnt == 16'(TIMEOUT - 1));

    // Held at zero outside BUSY, so it starts from zero on every entry
    always_ff @(posedge clk) begin
        if (rst)                to_cnt <= '0;
        else if (state != BUSY) to_cnt <= '0;
        else if (!ack_hit)      to_cnt <= to_cnt + 16'd1;
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.m_req) state_nxt = miss ? ERR : BUSY;
            BUSY:    if (ack_hit) state_nxt = DONE;
                     else if (timeout_hit) state_nxt = ERR;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && bus.m_req) begin
                if (miss) begin
                    rdata_q <= '0;
                end else begin
                    sel_q   <= hit;
                    we_q    <= bus.m_we;
                    addr_q  <= bus.m_addr;
                    wdata_q <= bus.m_wdata;
                    be_q    <= bus.m_be;
                end
            end
            if (state == BUSY) begin
                if (ack_hit) begin
                    sel_q   <= '0;
                    rdata_q <= slv_rdata;
                end else if (timeout_hit) begin
                    sel_q   <= '0;
                    rdata_q <= '0;
                end
            end
        end
    end

    assign bus.m_ready = (state == DONE) || (state == ERR);
    assign bus.m_err   = (state == ERR);
    assign bus.m_rdata = rdata_q;
    assign bus.s_sel   = sel_q;
    assign bus.s_we    = we_q;
    assign bus.s_addr  = addr_q;
    assign bus.s_wdata = wdata_q;
    assign bus.s_be    = be_q;

endmodule

// File: doc/bus_demux.md
BUS_DEMUX -- requirements
Module: bus_demux

Interface
REQ-001 Parameter: BASE0, 32'h0000_0000, match base of slave 0 (data RAM).
REQ-002 Parameter: MASK0, 32'hFFFF_C000, match mask of slave 0.
REQ-003 Parameter: BASE1/MASK1, 32'hFFFF_0000/32'hFFFF_FF00, slave 1 (LED/switch I/O).
REQ-004 Parameter: BASE2/MASK2, 32'hFFFF_0100/32'hFFFF_FF00, slave 2 (timer).
REQ-005 Parameter: BASE3/MASK3, 32'hFFFF_0200/32'hFFFF_FF00, slave 3 (UART).
REQ-006 Parameter: TIMEOUT, 16, ack wait limit in cycles (2..65535).
REQ-007 Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- m_req  in  1  master request strobe.
- m_we  in  1  1 = write, 0 = read.
- m_addr  in  32  byte address.
- m_wdata  in  32  write data.
- m_be  in  4  byte enables.
- m_ready  out  1  one-cycle completion pulse.
- m_err  out  1  error flag, valid with m_ready.
- m_rdata  out  32  read data, valid with m_ready.
- s_sel  out  4  one-hot slave select.
- s_we, s_addr, s_wdata, s_be  out  1/32/32/4  registered copies of the request.
- s_ack  in  4  per-slave acknowledge.
- s_rdata  in  128  packed slave read data; slave k drives bits [32k+31:32k].

Function
REQ-008 The block SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE, plus IDLE -> ERR -> IDLE.
REQ-009 In IDLE, m_req=1 SHALL decode m_addr, where slave k matches when (m_addr & MASKk) == BASEk, and the lowest matching index wins.
REQ-010 On a match, the block SHALL register we/addr/wdata/be and enter BUSY, with s_sel[k]=1 from the next cycle.
REQ-011 With no match, the block SHALL enter ERR, keep s_sel=0, and in ERR drive m_ready=1, m_err=1, m_rdata=0 for exactly one cycle.
REQ-012 In BUSY, s_sel and the s_* request outputs SHALL be held stable until s_ack[k]=1 is sampled.
- On that edge: capture s_rdata slice k into m_rdata and enter DONE.
- Acks from unselected slaves SHALL be ignored.
REQ-013 DONE SHALL drive m_ready=1, m_err=0, s_sel=0 for one cycle, then return to IDLE.
REQ-014 Minimum latency SHALL be 2 cycles: m_req at edge N, s_sel high after N, ack sampled at N+1, m_ready high after N+1.
REQ-015 m_req SHALL be ignored outside IDLE.
- The earliest next acceptance is the cycle after m_ready.
- Back-to-back issue period SHALL be 3 cycles minimum.
REQ-016 m_rdata SHALL hold its last value outside completion cycles, and SHALL be 0 after an ERR completion.
REQ-017 For writes, m_rdata SHALL still be captured from the slave on ack (value don't-care for the master).

Reset
REQ-018 rst=1 at a clock edge SHALL force IDLE and drive m_ready=0, m_err=0, m_rdata=0, s_sel=0, s_we=0, s_addr=0, s_wdata=0, s_be=0, and timeout counter=0.
REQ-019 Reset in BUSY SHALL abort the transfer with no m_ready pulse, and s_sel SHALL be 0 in the following cycle.

Configuration
REQ-020 Macro BUS_DEMUX_TIMEOUT_EN defined: a counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
- When it reaches TIMEOUT-1 without ack, the next state SHALL be ERR, giving m_ready=1, m_err=1, m_rdata=0 and dropping s_sel.
- An ack in the same cycle as the limit SHALL win, completing normally.
REQ-021 Macro undefined: there SHALL be no counter, and BUSY SHALL wait indefinitely for ack.

Structure
REQ-022 Shared package bus_pkg SHALL hold the FSM state encoding (IDLE, BUSY, DONE, ERR), NSLV=4, and default base/mask constants.
REQ-023 Address matching SHALL be a combinational sub-module bus_addr_decode (addr in; one-hot hit[3:0] and miss out; lowest-index priority).

Verification
REQ-024 Read m_addr=32'h0000_0010, slave 0 acks in the same cycle as sel with data 32'hDEAD_BEEF -> s_sel=4'b0001 for 1 cycle; m_ready, m_err=0, m_rdata=32'hDEAD_BEEF, 2 cycles after m_req.
REQ-025 Write m_addr=32'hFFFF_0104, data 32'h1234_5678, be=4'hF, slave 2 acks after 3 wait cycles -> s_sel=4'b0100 held 4 cycles with stable s_wdata; then one m_ready pulse.
REQ-026 Read m_addr=32'h8000_0000 (unmapped) -> s_sel stays 0; m_ready=1, m_err=1, m_rdata=0 one cycle later.
REQ-027 TIMEOUT=16, macro on, slave 3 never acks -> s_sel[3] high for 16 cycles, then m_err pulse; macro off -> BUSY persists for 1000 cycles.
REQ-028 rst asserted in the 2nd BUSY cycle, ack arrives the next cycle -> no m_ready, all outputs 0, and a fresh request after reset completes normally.
REQ-029 s_ack=4'b0010 while slave 0 is selected -> ignored, with no completion until s_ack[0].
